// File: rtl/tsn_rst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tsn_rst_pkg
// Purpose  : Shared types and helpers for the TSN reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package tsn_rst_pkg;

  // Sequencer states; values are fixed so status readback stays stable.
  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } rst_state_t;

  // Cause vector carries one bit per external source plus the software bit.
  function automatic int cause_w(input int num_src);
    return num_src + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tsn_rst_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : tsn_rst_sequencer_if
// Purpose  : Reset request inputs and status/domain outputs of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface tsn_rst_sequencer_if #(
  parameter int NUM_SRC = 3,
  parameter int NUM_DOM = 4
);
  import tsn_rst_pkg::*;

  logic [NUM_SRC-1:0]          iv_rst_src_n;
  logic                        i_sw_rst;
  logic                        i_clr_cause;
  logic [NUM_DOM-1:0]          ov_dom_rst_n;
  logic                        o_all_ready;
  logic                        o_rst_done_pulse;
  logic                        o_timer_rst;
  logic [cause_w(NUM_SRC)-1:0] ov_rst_cause;
  logic                        o_init_led;

  // Requester side: drives reset requests, observes status.
  modport master (
    output iv_rst_src_n, i_sw_rst, i_clr_cause,
    input  ov_dom_rst_n, o_all_ready, o_rst_done_pulse, o_timer_rst,
           ov_rst_cause, o_init_led
  );

  // Sequencer side.
  modport slave (
    input  iv_rst_src_n, i_sw_rst, i_clr_cause,
    output ov_dom_rst_n, o_all_ready, o_rst_done_pulse, o_timer_rst,
           ov_rst_cause, o_init_led
  );

endinterface
`default_nettype wire

// File: rtl/tsn_rst_sequencer_rst_src_sync.sv
`default_nettype none
// ============================================================================
// Module   : rst_src_sync
// Purpose  : Two-flop synchroniser for the asynchronous reset source lines.
//            Flops clear to 0 so every source reads as active after reset.
// Revision : 1.0 - initial release
// ============================================================================
module rst_src_sync #(
  parameter int WIDTH = 3
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] async_in,
  output logic      [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of the asynchronous source levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tsn_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tsn_rst_sequencer
// Purpose  : Merges external/software reset requests, stretches the merged
//            reset and releases the reset domains one at a time, index 0 first.
// Revision : 1.0 - initial release
// ============================================================================
module tsn_rst_sequencer
  import tsn_rst_pkg::*;
#(
  parameter int NUM_SRC        = 3,
  parameter int NUM_DOM        = 4,
  parameter int STRETCH_CYC    = 16,
  parameter int STAGGER_CYC    = 8,
  parameter int CNT_W          = 16,
  parameter int LED_BLINK_LOG2 = 4
) (
  input wire logic            i_clk,
  input wire logic            i_rst,
  tsn_rst_sequencer_if.slave  bus
);

  localparam int CAUSE_W = cause_w(NUM_SRC);
  localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOM - 1);

  logic [NUM_SRC-1:0]      src_sync;
  logic                    src_active;
  logic [CAUSE_W-1:0]      new_cause;
  rst_state_t              state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        dom_idx;
  logic [NUM_DOM-1:0]      dom_rst_n;
  logic                    all_ready;
  logic                    done_pulse;
  logic                    timer_rst;
  logic [CAUSE_W-1:0]      cause;
  logic [LED_BLINK_LOG2:0] blink;

  rst_src_sync #(.WIDTH(NUM_SRC)) u_sync (
    .clk      (i_clk),
    .rst      (i_rst),
    .async_in (bus.iv_rst_src_n),
    .sync_out (src_sync)
  );

  // Software request bypasses the synchroniser: it is already in this domain.
  assign src_active = (~&src_sync) | bus.i_sw_rst;
  assign new_cause  = {bus.i_sw_rst, ~src_sync};

  // Sequencer FSM: any active request sends every domain back into reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_ASSERT;
      cnt        <= '0;
      dom_idx    <= '0;
      dom_rst_n  <= '0;
      all_ready  <= 1'b0;
      done_pulse <= 1'b0;
      timer_rst  <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      timer_rst  <= 1'b0;
      if (src_active) begin
        state     <= ST_ASSERT;
        cnt       <= '0;
        dom_idx   <= '0;
        dom_rst_n <= '0;
        all_ready <= 1'b0;
      end else begin
        case (state)
          ST_ASSERT: begin
            state <= ST_STRETCH;
            cnt   <= '0;
          end
          ST_STRETCH: begin
            if (cnt == STRETCH_LAST) begin
              cnt          <= '0;
              dom_rst_n[0] <= 1'b1;
              if (NUM_DOM == 1) begin
                state      <= ST_RUN;
                all_ready  <= 1'b1;
                done_pulse <= 1'b1;
                timer_rst  <= 1'b1;
              end else begin
                state   <= ST_RELEASE;
                dom_idx <= IDX_W'(1);
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RELEASE: begin
            if (cnt == STAGGER_LAST) begin
              cnt                <= '0;
              dom_rst_n[dom_idx] <= 1'b1;
              if (dom_idx == IDX_LAST) begin
                state      <= ST_RUN;
                all_ready  <= 1'b1;
                done_pulse <= 1'b1;
                timer_rst  <= 1'b1;
              end else begin
                dom_idx <= dom_idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_RUN;
          end
        endcase
      end
    end
  end

  // Sticky cause bits; a cause arriving with a clear still gets recorded.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cause <= '0;
    end else if (src_active) begin
      cause <= (bus.i_clr_cause ? '0 : cause) | new_cause;
    end else if (bus.i_clr_cause) begin
      cause <= '0;
    end
  end

  // Free-running blink counter for the init LED.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink <= '0;
    end else begin
      blink <= blink + 1'b1;
    end
  end

  assign bus.ov_dom_rst_n     = dom_rst_n;
  assign bus.o_all_ready      = all_ready;
  assign bus.o_rst_done_pulse = done_pulse;
  assign bus.o_timer_rst      = timer_rst;
  assign bus.ov_rst_cause     = cause;
  assign bus.o_init_led       = (state == ST_RUN) |
                                (((state == ST_STRETCH) || (state == ST_RELEASE)) &
                                 blink[LED_BLINK_LOG2]);

endmodule
`default_nettype wire

// File: tb/tb_tsn_rst_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tsn_rst_sequencer
// Purpose  : Scoreboard bench for the reset sequencer (default and minimal
//            parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tsn_rst_sequencer;

  localparam int SC = 16;
  localparam int SG = 8;

  typedef struct {
    int         cyc;
    logic [6:0] obs;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_b = 1'b1;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rst_cyc = 0;
  logic mon_en  = 1'b0;
  logic [6:0] prev_obs = '0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of posedges so far.
  always @(posedge clk) cyc <= cyc + 1;

  tsn_rst_sequencer_if #(.NUM_SRC(3), .NUM_DOM(4)) bus_a ();
  tsn_rst_sequencer_if #(.NUM_SRC(3), .NUM_DOM(1)) bus_b ();

  tsn_rst_sequencer #(
    .NUM_SRC(3), .NUM_DOM(4), .STRETCH_CYC(SC), .STAGGER_CYC(SG),
    .CNT_W(16), .LED_BLINK_LOG2(4)
  ) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a)
  );

  tsn_rst_sequencer #(
    .NUM_SRC(3), .NUM_DOM(1), .STRETCH_CYC(1), .STAGGER_CYC(1),
    .CNT_W(16), .LED_BLINK_LOG2(4)
  ) dut_b (
    .i_clk (clk),
    .i_rst (rst_b),
    .bus   (bus_b)
  );

  // Scoreboard monitor: every change of {domains, ready, done, timer} must
  // match the next queued expectation, including the cycle it happens on.
  always @(negedge clk) begin : mon
    logic [6:0] obs;
    exp_t       e;
    obs = {bus_a.ov_dom_rst_n, bus_a.o_all_ready, bus_a.o_rst_done_pulse, bus_a.o_timer_rst};
    if (mon_en && (obs !== prev_obs)) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected cyc=%0d obs=%b required no change", cyc, obs);
      end else begin
        e = sb.pop_front();
        if ((e.cyc != cyc) || (e.obs !== obs)) begin
          n_fail++;
          $display("FAIL sb_event got cyc=%0d obs=%b required cyc=%0d obs=%b",
                   cyc, obs, e.cyc, e.obs);
        end
      end
    end
    prev_obs = obs;
  end

  task automatic push(input int c, input logic [3:0] d, input logic r, input logic p);
    sb.push_back('{cyc: c, obs: {d, r, p, p}});
  endtask

  // Full release sequence relative to the STRETCH entry edge e.
  task automatic push_seq(input int e);
    push(e + SC,          4'b0001, 1'b0, 1'b0);
    push(e + SC + SG,     4'b0011, 1'b0, 1'b0);
    push(e + SC + 2 * SG, 4'b0111, 1'b0, 1'b0);
    push(e + SC + 3 * SG, 4'b1111, 1'b1, 1'b1);
    push(e + SC + 3 * SG + 1, 4'b1111, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    int c;
    int exp_led;
    bus_a.iv_rst_src_n = 3'b111;
    bus_a.i_sw_rst     = 1'b0;
    bus_a.i_clr_cause  = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (bus_a.ov_dom_rst_n !== 4'b0000) begin n_fail++; $display("FAIL rst_dom got=%b required=0000", bus_a.ov_dom_rst_n); end
    n_tests++;
    if ({bus_a.o_all_ready, bus_a.o_rst_done_pulse, bus_a.o_timer_rst} !== 3'b000) begin
      n_fail++; $display("FAIL rst_flags got=%b required=000", {bus_a.o_all_ready, bus_a.o_rst_done_pulse, bus_a.o_timer_rst});
    end
    n_tests++;
    if (bus_a.ov_rst_cause !== 4'b0000) begin n_fail++; $display("FAIL rst_cause got=%b required=0000", bus_a.ov_rst_cause); end
    n_tests++;
    if (bus_a.o_init_led !== 1'b0) begin n_fail++; $display("FAIL rst_led got=%b required=0", bus_a.o_init_led); end
    rst = 1'b0;
    c = cyc;
    rst_cyc = c;
    mon_en = 1'b1;
    push_seq(c + 3);
    while (cyc < c + 2) @(negedge clk);
    n_tests++;
    if (bus_a.o_init_led !== 1'b0) begin n_fail++; $display("FAIL sync_fill_led got=%b required=0", bus_a.o_init_led); end
    while (cyc < c + 12) @(negedge clk);
    exp_led = ((cyc - rst_cyc) >> 4) & 1;
    n_tests++;
    if (bus_a.o_init_led !== exp_led[0]) begin n_fail++; $display("FAIL blink_stretch got=%b required=%0d", bus_a.o_init_led, exp_led); end
    while (cyc < c + 23) @(negedge clk);
    exp_led = ((cyc - rst_cyc) >> 4) & 1;
    n_tests++;
    if (bus_a.o_init_led !== exp_led[0]) begin n_fail++; $display("FAIL blink_release got=%b required=%0d", bus_a.o_init_led, exp_led); end
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL reset_seq_timeout pending=%0d required=0", sb.size()); sb.delete(); end
    n_tests++;
    if (bus_a.ov_rst_cause !== 4'b0111) begin n_fail++; $display("FAIL boot_cause got=%b required=0111", bus_a.ov_rst_cause); end
    n_tests++;
    if (bus_a.o_init_led !== 1'b1) begin n_fail++; $display("FAIL run_led got=%b required=1", bus_a.o_init_led); end
  endtask

  task automatic test_sw_reset();
    int c;
    bus_a.i_clr_cause = 1'b1;
    @(negedge clk);
    bus_a.i_clr_cause = 1'b0;
    n_tests++;
    if (bus_a.ov_rst_cause !== 4'b0000) begin n_fail++; $display("FAIL clr_cause got=%b required=0000", bus_a.ov_rst_cause); end
    bus_a.i_sw_rst = 1'b1;
    c = cyc;
    push(c + 1, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    bus_a.i_sw_rst = 1'b0;
    push_seq(c + 2);
    n_tests++;
    if (bus_a.ov_rst_cause !== 4'b1000) begin n_fail++; $display("FAIL sw_cause got=%b required=1000", bus_a.ov_rst_cause); end
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sw_seq_timeout pending=%0d required=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_src_release();
    int c;
    int e;
    int d;
    bus_a.i_sw_rst = 1'b1;
    c = cyc;
    push(c + 1, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    bus_a.i_sw_rst    = 1'b0;
    bus_a.i_clr_cause = 1'b1;
    e = c + 2;
    push(e + SC,      4'b0001, 1'b0, 1'b0);
    push(e + SC + SG, 4'b0011, 1'b0, 1'b0);
    @(negedge clk);
    bus_a.i_clr_cause = 1'b0;
    while (cyc < e + SC + SG + 2) @(negedge clk);
    bus_a.iv_rst_src_n[1] = 1'b0;
    d = cyc;
    push(d + 3, 4'b0000, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    n_tests++;
    if (bus_a.ov_rst_cause !== 4'b0010) begin n_fail++; $display("FAIL src1_cause got=%b required=0010", bus_a.ov_rst_cause); end
    bus_a.iv_rst_src_n[1] = 1'b1;
    push_seq(cyc + 3);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL src1_seq_timeout pending=%0d required=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_long_hold();
    int c;
    logic bad;
    bus_a.i_clr_cause = 1'b1;
    @(negedge clk);
    bus_a.i_clr_cause = 1'b0;
    bus_a.iv_rst_src_n[2] = 1'b0;
    c = cyc;
    push(c + 3, 4'b0000, 1'b0, 1'b0);
    bad = 1'b0;
    while (cyc < c + 3) @(negedge clk);
    while (cyc < c + 100) begin
      if ((bus_a.ov_dom_rst_n !== 4'b0000) || (bus_a.o_init_led !== 1'b0)) bad = 1'b1;
      @(negedge clk);
    end
    bus_a.iv_rst_src_n[2] = 1'b1;
    push_seq(c + 103);
    while (cyc < c + 103) begin
      if ((bus_a.ov_dom_rst_n !== 4'b0000) || (bus_a.o_init_led !== 1'b0)) bad = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL hold_assert got=1 required=0 (domains/led left 0 during hold)"); end
    n_tests++;
    if (bus_a.ov_rst_cause !== 4'b0100) begin n_fail++; $display("FAIL src2_cause got=%b required=0100", bus_a.ov_rst_cause); end
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL hold_seq_timeout pending=%0d required=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_clr_race();
    int c;
    bus_a.i_sw_rst    = 1'b1;
    bus_a.i_clr_cause = 1'b1;
    c = cyc;
    push(c + 1, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    bus_a.i_sw_rst    = 1'b0;
    bus_a.i_clr_cause = 1'b0;
    push_seq(c + 2);
    n_tests++;
    if (bus_a.ov_rst_cause !== 4'b1000) begin n_fail++; $display("FAIL race_cause got=%b required=1000", bus_a.ov_rst_cause); end
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL race_seq_timeout pending=%0d required=0", sb.size()); sb.delete(); end
    bus_a.i_clr_cause = 1'b1;
    @(negedge clk);
    bus_a.i_clr_cause = 1'b0;
    n_tests++;
    if (bus_a.ov_rst_cause !== 4'b0000) begin n_fail++; $display("FAIL lone_clr got=%b required=0000", bus_a.ov_rst_cause); end
  endtask

  task automatic test_min_params();
    int c;
    n_tests++;
    if ({bus_b.ov_dom_rst_n, bus_b.o_all_ready, bus_b.o_rst_done_pulse, bus_b.o_timer_rst, bus_b.o_init_led} !== 5'b00000) begin
      n_fail++; $display("FAIL min_rst got=%b required=00000",
                         {bus_b.ov_dom_rst_n, bus_b.o_all_ready, bus_b.o_rst_done_pulse, bus_b.o_timer_rst, bus_b.o_init_led});
    end
    rst_b = 1'b0;
    c = cyc;
    while (cyc < c + 3) @(negedge clk);
    n_tests++;
    if ({bus_b.ov_dom_rst_n, bus_b.o_all_ready} !== 2'b00) begin
      n_fail++; $display("FAIL min_stretch got=%b required=00", {bus_b.ov_dom_rst_n, bus_b.o_all_ready});
    end
    @(negedge clk);
    n_tests++;
    if ({bus_b.ov_dom_rst_n, bus_b.o_all_ready, bus_b.o_rst_done_pulse, bus_b.o_timer_rst, bus_b.o_init_led} !== 5'b11111) begin
      n_fail++; $display("FAIL min_run got=%b required=11111",
                         {bus_b.ov_dom_rst_n, bus_b.o_all_ready, bus_b.o_rst_done_pulse, bus_b.o_timer_rst, bus_b.o_init_led});
    end
    @(negedge clk);
    n_tests++;
    if ({bus_b.ov_dom_rst_n, bus_b.o_all_ready, bus_b.o_rst_done_pulse, bus_b.o_timer_rst, bus_b.o_init_led} !== 5'b11001) begin
      n_fail++; $display("FAIL min_pulse_end got=%b required=11001",
                         {bus_b.ov_dom_rst_n, bus_b.o_all_ready, bus_b.o_rst_done_pulse, bus_b.o_timer_rst, bus_b.o_init_led});
    end
  endtask

  initial begin
    bus_b.iv_rst_src_n = 3'b111;
    bus_b.i_sw_rst     = 1'b0;
    bus_b.i_clr_cause  = 1'b0;
    test_reset();
    test_sw_reset();
    test_src_release();
    test_long_hold();
    test_clr_race();
    test_min_params();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish before limit", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
